// File: rtl/alu_ctl_pkg.sv
// alu_ctl_pkg: shared encodings for the registered ALU control decoder.
//   - alu_ctl codes (4-bit; zero-extended to CTL_W by the consumer)
//   - ALUOp encodings, R-type funct and imm_op selector constants
//   - mult/div op enum and decode result struct
package alu_ctl_pkg;

  // alu_ctl codes
  localparam logic [3:0] ALU_AND     = 4'd0;
  localparam logic [3:0] ALU_OR      = 4'd1;
  localparam logic [3:0] ALU_ADD     = 4'd2;
  localparam logic [3:0] ALU_XOR     = 4'd3;
  localparam logic [3:0] ALU_SLL     = 4'd4;
  localparam logic [3:0] ALU_SRL     = 4'd5;
  localparam logic [3:0] ALU_SUB     = 4'd6;
  localparam logic [3:0] ALU_SLT     = 4'd7;
  localparam logic [3:0] ALU_SRA     = 4'd8;
  localparam logic [3:0] ALU_SLTU    = 4'd9;
  localparam logic [3:0] ALU_LUI     = 4'd10;
  localparam logic [3:0] ALU_PASS    = 4'd11;
  localparam logic [3:0] ALU_NOR     = 4'd12;
  localparam logic [3:0] ALU_INVALID = 4'd15;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // R-type funct
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // imm_op selector
  localparam logic [2:0] IMM_ADDI  = 3'd0;
  localparam logic [2:0] IMM_ANDI  = 3'd1;
  localparam logic [2:0] IMM_ORI   = 3'd2;
  localparam logic [2:0] IMM_XORI  = 3'd3;
  localparam logic [2:0] IMM_SLTI  = 3'd4;
  localparam logic [2:0] IMM_SLTIU = 3'd5;
  localparam logic [2:0] IMM_LUI   = 3'd6;
  localparam logic [2:0] IMM_ILL   = 3'd7;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef struct packed {
    logic [3:0] ctl;
    logic       illegal;
    logic       is_md;    // launches the mult/div unit
    md_op_e     md_op;
  } dec_t;

  // Functs that read HI/LO or occupy the mult/div unit.
  function automatic logic is_hilo(input logic [5:0] fn);
    return (fn == FN_MFHI) || (fn == FN_MFLO) || (fn[5:2] == FN_MULT[5:2]);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: loadable down-counter tracking the mult/div unit.
//   clk, rst_n : clock, async active-low reset
//   load       : a mult/div was accepted this cycle
//   is_div     : selects DIV_CYCLES (1) or MULT_CYCLES (0) on load
//   busy       : counter nonzero; high for exactly N cycles after load
module md_busy_counter #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;

  // Load wins over decrement; the top never loads while busy because
  // mult/div instructions stall until the count drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    else if (cnt != '0)    cnt <= cnt - CW'(1);
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered ALU control decode at the ID/EX boundary,
// plus sequencing/stall for the multi-cycle mult/div unit.
//   clk, rst_n          : clock, async active-low reset
//   in_valid            : ID presents a valid instruction
//   alu_op[1:0]         : 00 add, 01 sub, 10 R-type (func_code), 11 imm (imm_op)
//   func_code[5:0]      : R-type funct
//   imm_op[2:0]         : immediate-op selector
//   flush               : squash the instruction being captured
//   stall               : comb; HI/LO or mult/div instruction while unit busy
//   out_valid           : registered alu_ctl valid for EX
//   alu_ctl[CTL_W-1:0]  : registered control code (15 = invalid)
//   illegal             : registered; accepted instruction was undefined
//   md_start, md_op     : registered one-cycle launch pulse and operation
//   md_busy             : mult/div unit still computing
// CTL_W must be >= 4; MULT_CYCLES/DIV_CYCLES must be >= 1.
module alu_control_seq
  import alu_ctl_pkg::*;
#(
  parameter int CTL_W         = 4,
  parameter int MULT_CYCLES   = 4,
  parameter int DIV_CYCLES    = 32,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func_code,
  input  logic [2:0]       imm_op,
  input  logic             flush,
  output logic             stall,
  output logic             out_valid,
  output logic [CTL_W-1:0] alu_ctl,
  output logic             illegal,
  output logic             md_start,
  output logic [1:0]       md_op,
  output logic             md_busy
);

  function automatic dec_t decode(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [2:0] im);
    dec_t d;
    d.ctl     = ALU_INVALID;
    d.illegal = 1'b0;
    d.is_md   = 1'b0;
    d.md_op   = MD_MULT;
    case (op)
      ALUOP_ADD: d.ctl = ALU_ADD;
      ALUOP_SUB: d.ctl = ALU_SUB;
      ALUOP_RTYPE: begin
        // Full 6-bit compare: no aliasing on the low nibble.
        case (fn)
          FN_ADD, FN_ADDU: d.ctl = ALU_ADD;
          FN_SUB, FN_SUBU: d.ctl = ALU_SUB;
          FN_AND:          d.ctl = ALU_AND;
          FN_OR:           d.ctl = ALU_OR;
          FN_XOR:          d.ctl = ALU_XOR;
          FN_NOR:          d.ctl = ALU_NOR;
          FN_SLT:          d.ctl = ALU_SLT;
          FN_SLTU:         d.ctl = ALU_SLTU;
          FN_SLL:          d.ctl = ALU_SLL;
          FN_SRL:          d.ctl = ALU_SRL;
          FN_SRA:          d.ctl = ALU_SRA;
          FN_MFHI, FN_MFLO: begin
            if (ENABLE_MULDIV != 0) d.ctl = ALU_PASS;
            else                    d.illegal = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            if (ENABLE_MULDIV != 0) begin
              d.ctl   = ALU_PASS;
              d.is_md = 1'b1;
              d.md_op = md_op_e'(fn[1:0]);
            end else begin
              d.illegal = 1'b1;
            end
          end
          default: d.illegal = 1'b1;
        endcase
      end
      default: begin  // ALUOP_IMM
        case (im)
          IMM_ADDI:  d.ctl = ALU_ADD;
          IMM_ANDI:  d.ctl = ALU_AND;
          IMM_ORI:   d.ctl = ALU_OR;
          IMM_XORI:  d.ctl = ALU_XOR;
          IMM_SLTI:  d.ctl = ALU_SLT;
          IMM_SLTIU: d.ctl = ALU_SLTU;
          IMM_LUI:   d.ctl = ALU_LUI;
          default:   d.illegal = 1'b1;  // IMM_ILL
        endcase
      end
    endcase
    return d;
  endfunction

  dec_t dec;
  logic accept;
  logic cnt_busy;

  assign dec = decode(alu_op, func_code, imm_op);

  // Only HI/LO readers and new mult/div ops wait on the unit; flush does not
  // mask stall so ID/IF hold stays consistent with the busy window.
  assign stall  = in_valid & md_busy & (alu_op == ALUOP_RTYPE) & is_hilo(func_code);
  assign accept = in_valid & ~stall & ~flush;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept & dec.is_md),
    .is_div (dec.md_op[1]),
    .busy   (cnt_busy)
  );

  assign md_busy = (ENABLE_MULDIV != 0) && cnt_busy;

  // alu_ctl/illegal/md_op hold across bubbles; only the valid bits pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_ctl   <= CTL_W'(ALU_INVALID);
      illegal   <= 1'b0;
      md_start  <= 1'b0;
      md_op     <= 2'd0;
    end else begin
      out_valid <= accept;
      md_start  <= accept & dec.is_md;
      if (accept) begin
        alu_ctl <= CTL_W'(dec.ctl);
        illegal <= dec.illegal;
      end
      if (accept & dec.is_md) md_op <= dec.md_op;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
module tb_alu_control_seq;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;

  logic       clk, rst_n;
  logic       in_valid, flush;
  logic [1:0] alu_op;
  logic [5:0] func_code;
  logic [2:0] imm_op;
  logic       stall, out_valid, illegal, md_start, md_busy;
  logic [3:0] alu_ctl;
  logic [1:0] md_op;

  alu_control_seq #(
    .CTL_W(4), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .ENABLE_MULDIV(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_op(alu_op),
    .func_code(func_code), .imm_op(imm_op), .flush(flush), .stall(stall),
    .out_valid(out_valid), .alu_ctl(alu_ctl), .illegal(illegal),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int rtab[64];               // R-type funct -> code, 15 = undefined
  int itab[8] = '{2, 0, 1, 3, 7, 9, 10, 15};
  int e;                      // posedges since reset release
  int exp_ctl, exp_mdop;
  logic exp_ov, exp_ill, exp_start;
  logic have_md;
  int md_e, md_n;             // busy after edges md_e .. md_e+md_n-1
  logic stall_seen;

  function automatic logic busy_at(input int k);
    return have_md && k >= md_e && k < md_e + md_n;
  endfunction

  function automatic logic needs_unit(input logic [5:0] fn);
    int f = int'(fn);
    return f == 'h10 || f == 'h12 || (f >= 'h18 && f <= 'h1B);
  endfunction

  task automatic ref_dec(input logic [1:0] op, input logic [5:0] fn, input logic [2:0] im,
                         output int ctl, output logic ill, output logic md);
    md = 1'b0;
    case (op)
      2'd0: ctl = 2;
      2'd1: ctl = 6;
      2'd2: begin
        ctl = rtab[fn];
        md  = int'(fn) >= 'h18 && int'(fn) <= 'h1B;
      end
      default: ctl = itab[im];
    endcase
    ill = (ctl == 15);
  endtask

  task automatic model_reset();
    exp_ov = 0; exp_ctl = 15; exp_ill = 0; exp_start = 0; exp_mdop = 0;
    have_md = 0; md_e = 0; md_n = 0; e = 0;
  endtask

  // One cycle: drive at posedge+1, check stall at posedge+4, outputs at next posedge+1.
  task automatic step(input logic iv, input logic [1:0] op, input logic [5:0] fn,
                      input logic [2:0] im, input logic fl);
    int c; logic il, md, es, acc;
    in_valid = iv; alu_op = op; func_code = fn; imm_op = im; flush = fl;
    #3;
    es = iv && busy_at(e) && op == 2'd2 && needs_unit(fn);
    stall_seen = stall;
    chk("stall", stall, es);
    acc = iv && !es && !fl;
    ref_dec(op, fn, im, c, il, md);
    exp_ov = acc;
    if (acc) begin exp_ctl = c; exp_ill = il; end
    exp_start = acc && md;
    if (exp_start) begin
      exp_mdop = int'(fn[1:0]);
      have_md = 1; md_e = e + 1; md_n = fn[1] ? DIV_N : MULT_N;
    end
    @(posedge clk); #1; e++;
    chk("out_valid", out_valid, exp_ov);
    chk("alu_ctl",   alu_ctl,   exp_ctl);
    chk("illegal",   illegal,   exp_ill);
    chk("md_start",  md_start,  exp_start);
    chk("md_op",     md_op,     exp_mdop);
    chk("md_busy",   md_busy,   busy_at(e));
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 6'd0, 3'd0, 1'b0);
  endtask

  int fn_pool[22] = '{'h00, 'h02, 'h03, 'h10, 'h12, 'h18, 'h19, 'h1A, 'h1B, 'h20, 'h21,
                      'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h01, 'h11, 'h28};

  initial begin
    int n, nb;
    logic [5:0] rf;
    foreach (rtab[i]) rtab[i] = 15;
    rtab['h20] = 2;  rtab['h21] = 2;  rtab['h22] = 6;  rtab['h23] = 6;
    rtab['h24] = 0;  rtab['h25] = 1;  rtab['h26] = 3;  rtab['h27] = 12;
    rtab['h2A] = 7;  rtab['h2B] = 9;  rtab['h00] = 4;  rtab['h02] = 5;
    rtab['h03] = 8;  rtab['h10] = 11; rtab['h12] = 11;
    for (int f = 'h18; f <= 'h1B; f++) rtab[f] = 11;

    rst_n = 0; in_valid = 0; alu_op = 0; func_code = 0; imm_op = 0; flush = 0;
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_ctl",   alu_ctl,   15);
    chk("rst_illegal",   illegal,   0);
    chk("rst_md_start",  md_start,  0);
    chk("rst_md_op",     md_op,     0);
    chk("rst_md_busy",   md_busy,   0);
    chk("rst_stall",     stall,     0);
    rst_n = 1;
    @(posedge clk); #1;

    // Basic decodes
    step(1, 2'd2, 6'h22, 0, 0);
    step(1, 2'd2, 6'h27, 0, 0);
    step(1, 2'd3, 6'h00, 3'd6, 0);
    step(1, 2'd3, 6'h00, 3'd7, 0);
    step(1, 2'd0, 6'h3F, 0, 0);
    step(1, 2'd1, 6'h3F, 0, 0);
    idle();

    // DIV then MFLO waits 32 cycles
    step(1, 2'd2, 6'h1A, 0, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 2'd2, 6'h12, 0, 0);
      if (!stall_seen) break;
      n++;
    end
    chk("div_stall_cycles", n, DIV_N);
    idle();

    // MULT then ADD: no stall, busy exactly 4 cycles
    step(1, 2'd2, 6'h18, 0, 0);
    nb = int'(md_busy);
    step(1, 2'd2, 6'h20, 0, 0);
    nb += int'(md_busy);
    for (int i = 0; i < 6; i++) begin idle(); nb += int'(md_busy); end
    chk("mult_busy_cycles", nb, MULT_N);

    // Flush with MULTU
    step(1, 2'd2, 6'h19, 0, 1);
    chk("flush_no_busy", md_busy, 0);
    idle();

    // Reset mid-DIV
    step(1, 2'd2, 6'h1B, 0, 0);
    for (int i = 0; i < 22; i++) idle();
    in_valid = 1; alu_op = 2'd2; func_code = 6'h10; imm_op = 0; flush = 0;
    #1;
    chk("pre_rst_stall", stall, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_alu_ctl",   alu_ctl,   15);
    chk("mid_rst_illegal",   illegal,   0);
    chk("mid_rst_md_start",  md_start,  0);
    chk("mid_rst_md_op",     md_op,     0);
    chk("mid_rst_md_busy",   md_busy,   0);
    chk("mid_rst_stall",     stall,     0);
    in_valid = 0;
    rst_n = 1;
    model_reset();
    @(posedge clk); #1; e++;
    step(1, 2'd2, 6'h10, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(1, 0) == 1) rf = 6'(fn_pool[$urandom_range(21, 0)]);
      else                           rf = 6'($urandom_range(63, 0));
      step(logic'($urandom_range(3, 0) != 0), 2'($urandom_range(3, 0)), rf,
           3'($urandom_range(7, 0)), logic'($urandom_range(7, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
